// File: rtl/bpu_gshare_pred.sv
`default_nettype none
// bpu_gshare_pred -- gshare direction + tagged direct-mapped BTB, one fetch-block
// prediction per cycle, with a post-reset table-clear sweep.  Rev 1.0
module bpu_gshare_pred #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          PHT_DEPTH   = 1024,
  parameter int          GHR_LEN     = 10,
  parameter int          BTB_DEPTH   = 256,
  parameter int          TAG_LEN     = 8,
  parameter logic [31:0] INIT_PC     = 32'h1c000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [31:0]              redir_addr_i,
  input  logic [GHR_LEN-1:0]       redir_ghr_i,
  input  logic                     upd_valid_i,
  input  logic [31:0]              upd_pc_i,
  input  logic [GHR_LEN-1:0]       upd_ghr_i,
  input  logic                     upd_is_cond_i,
  input  logic                     upd_taken_i,
  input  logic                     upd_btb_we_i,
  input  logic [31:0]              upd_target_i,
  output logic                     pred_valid_o,
  input  logic                     pred_ready_i,
  output logic [31:0]              pred_pc_o,
  output logic [FETCH_WIDTH-1:0]   pred_mask_o,
  output logic [FETCH_WIDTH-1:0]   pred_taken_o,
  output logic [31:0]              pred_next_pc_o,
  output logic [GHR_LEN-1:0]       pred_ghr_o,
  output logic [2*FETCH_WIDTH-1:0] pred_scnt_o
);

  localparam int PHT_LEN   = $clog2(PHT_DEPTH);
  localparam int BTB_LEN   = $clog2(BTB_DEPTH);
  localparam int OFF_LEN   = $clog2(FETCH_WIDTH) + 2;
  localparam int SLOT_LEN  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int CLR_DEPTH = (PHT_DEPTH > BTB_DEPTH) ? PHT_DEPTH : BTB_DEPTH;
  localparam int CLR_LEN   = (CLR_DEPTH > 1) ? $clog2(CLR_DEPTH) : 1;
  localparam logic [CLR_LEN:0]   PHT_LIM  = (CLR_LEN+1)'(PHT_DEPTH);
  localparam logic [CLR_LEN:0]   BTB_LIM  = (CLR_LEN+1)'(BTB_DEPTH);
  localparam logic [CLR_LEN-1:0] CLR_LAST = CLR_LEN'(CLR_DEPTH - 1);

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [CLR_LEN-1:0]   clr_idx, clr_idx_nxt;
  logic [31:0]          pc;
  logic [GHR_LEN-1:0]   ghr, ghr_fire;

  logic [1:0]           pht        [PHT_DEPTH];
  logic                 btb_valid  [BTB_DEPTH];
  logic [TAG_LEN-1:0]   btb_tag    [BTB_DEPTH];
  logic [31:0]          btb_target [BTB_DEPTH];
  logic                 btb_cond   [BTB_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    if (state == CLEAR) begin
      clr_idx_nxt = clr_idx + CLR_LEN'(1);
      if (clr_idx == CLR_LAST) begin
        state_nxt   = RUN;
        clr_idx_nxt = '0;
      end
    end
  end

  // Block addressing and per-slot table lookups
  logic [31:0]          base;
  logic [SLOT_LEN-1:0]  start_slot;
  logic [31:0]          slot_pc  [FETCH_WIDTH];
  logic [31:0]          slot_tgt [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] slot_on, slot_hit, slot_cond, slot_taken;

  assign base = {pc[31:OFF_LEN], {OFF_LEN{1'b0}}};

  if (FETCH_WIDTH > 1) begin : g_start_multi
    assign start_slot = pc[OFF_LEN-1:2];
  end else begin : g_start_single
    assign start_slot = '0;
  end

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
    logic [BTB_LEN-1:0] bidx;
    logic [PHT_LEN-1:0] pidx;
    logic               unused_slot_bits;
    assign slot_pc[i]        = base + 32'(4 * i);
    assign bidx              = slot_pc[i][BTB_LEN+1:2];
    assign pidx              = slot_pc[i][PHT_LEN+1:2] ^ PHT_LEN'(ghr);
    assign slot_on[i]        = (SLOT_LEN'(i) >= start_slot);
    assign slot_hit[i]       = btb_valid[bidx] &&
                               (btb_tag[bidx] == slot_pc[i][BTB_LEN+TAG_LEN+1:BTB_LEN+2]);
    assign slot_cond[i]      = btb_cond[bidx];
    assign slot_tgt[i]       = btb_target[bidx];
    assign pred_scnt_o[2*i +: 2] = pht[pidx];
    assign slot_taken[i]     = slot_on[i] && slot_hit[i] && (!slot_cond[i] || pht[pidx][1]);
    assign unused_slot_bits  = ^slot_pc[i];
  end

  logic                found, cond_hit;
  logic [SLOT_LEN-1:0] first;

  always_comb begin
    found       = 1'b0;
    first       = '0;
    cond_hit    = 1'b0;
    pred_mask_o = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (slot_taken[i]) begin
        found = 1'b1;
        first = SLOT_LEN'(i);
      end
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pred_mask_o[i] = slot_on[i] && (!found || (SLOT_LEN'(i) <= first));
      if (slot_on[i] && slot_hit[i] && slot_cond[i]) cond_hit = 1'b1;
    end
  end

  // An unconditional taken branch leaves history untouched
  always_comb begin
    ghr_fire = ghr;
    if (found) begin
      if (slot_cond[first]) ghr_fire = GHR_LEN'({ghr, 1'b1});
    end else if (cond_hit) begin
      ghr_fire = GHR_LEN'({ghr, 1'b0});
    end
  end

  assign pred_valid_o   = (state == RUN);
  assign pred_pc_o      = pc;
  assign pred_ghr_o     = ghr;
  assign pred_taken_o   = slot_taken;
  assign pred_next_pc_o = found ? slot_tgt[first] : base + 32'(4 * FETCH_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= INIT_PC;
      ghr <= '0;
    end else if (flush_i) begin
      pc  <= redir_addr_i;
      ghr <= redir_ghr_i;
    end else if (pred_valid_o && pred_ready_i) begin
      pc  <= pred_next_pc_o;
      ghr <= ghr_fire;
    end
  end

  // Training: read-modify-write of the addressed counter, plus BTB fill
  logic                train;
  logic [PHT_LEN-1:0]  upd_pidx;
  logic [BTB_LEN-1:0]  upd_bidx;
  logic [1:0]          upd_cnt, upd_cnt_new;
  logic                unused_upd_bits;

  assign train           = (state == RUN) && upd_valid_i && !rst;
  assign upd_pidx        = upd_pc_i[PHT_LEN+1:2] ^ PHT_LEN'(upd_ghr_i);
  assign upd_bidx        = upd_pc_i[BTB_LEN+1:2];
  assign upd_cnt         = pht[upd_pidx];
  assign unused_upd_bits = ^upd_pc_i;

  always_comb begin
    upd_cnt_new = upd_cnt;
    if (upd_taken_i) begin
      if (upd_cnt != 2'b11) upd_cnt_new = upd_cnt + 2'b01;
    end else if (upd_cnt != 2'b00) begin
      upd_cnt_new = upd_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      if ({1'b0, clr_idx} < PHT_LIM) pht[clr_idx[PHT_LEN-1:0]] <= 2'b01;
      if ({1'b0, clr_idx} < BTB_LIM) btb_valid[clr_idx[BTB_LEN-1:0]] <= 1'b0;
    end else if (train) begin
      if (upd_is_cond_i) pht[upd_pidx] <= upd_cnt_new;
      if (upd_btb_we_i) begin
        btb_valid[upd_bidx]  <= 1'b1;
        btb_tag[upd_bidx]    <= upd_pc_i[BTB_LEN+TAG_LEN+1:BTB_LEN+2];
        btb_target[upd_bidx] <= upd_target_i;
        btb_cond[upd_bidx]   <= upd_is_cond_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/bpu_gshare_pred.md
Name: bpu_gshare_pred

Overview:
Parametrised next-generation front-end branch predictor. It produces one fetch-block prediction per cycle for FETCH_WIDTH instruction slots. Direction comes from a gshare PHT indexed by PC XOR a speculative global history register (GHR); targets come from a tagged direct-mapped BTB. It adds a post-reset table-clear FSM, speculative GHR with flush repair, and read-modify-write counter training. The block sits ahead of the fetch stage and receives one backend update per cycle.

Parameters:
FETCH_WIDTH, 2, instruction slots per fetch block; power of 2, range 1..8.
PHT_DEPTH, 1024, PHT entries of 2-bit counters; power of 2; PHT_LEN = log2(PHT_DEPTH).
GHR_LEN, 10, global history bits; must be <= PHT_LEN.
BTB_DEPTH, 256, BTB entries; power of 2; BTB_LEN = log2(BTB_DEPTH).
TAG_LEN, 8, BTB tag bits.
INIT_PC, 32'h1c000000, fetch PC after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush_i  in  1  redirect from backend
redir_addr_i  in  32  new fetch PC on flush
redir_ghr_i  in  GHR_LEN  repaired GHR on flush
upd_valid_i  in  1  training update strobe
upd_pc_i  in  32  PC of resolved branch
upd_ghr_i  in  GHR_LEN  GHR snapshot from prediction time
upd_is_cond_i  in  1  branch is conditional (train PHT)
upd_taken_i  in  1  resolved direction
upd_btb_we_i  in  1  write BTB entry
upd_target_i  in  32  resolved target
pred_valid_o  out  1  prediction valid
pred_ready_i  in  1  consumer accepts prediction
pred_pc_o  out  32  current fetch PC
pred_mask_o  out  FETCH_WIDTH  valid slots in block
pred_taken_o  out  FETCH_WIDTH  per-slot predicted taken
pred_next_pc_o  out  32  predicted next fetch PC
pred_ghr_o  out  GHR_LEN  GHR used for this prediction
pred_scnt_o  out  2*FETCH_WIDTH  per-slot counter read, slot i at [2i+1:2i]

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: pc=INIT_PC, ghr=0, FSM=CLEAR, clear index=0, pred_valid_o=0.
- CLEAR FSM:
  - One index per cycle. Writes PHT[idx]=2'b01 (weakly not-taken) and BTB[idx].valid=0 while idx is below the respective depth.
  - Runs for max(PHT_DEPTH, BTB_DEPTH) cycles, then moves to RUN.
  - pred_valid_o=0 throughout CLEAR.
  - Updates during CLEAR are dropped.
  - A flush during CLEAR loads pc and ghr but does not exit CLEAR.
  - rst at any time restarts CLEAR from index 0.
- RUN: pred_valid_o=1 continuously. Outputs are combinational from pc, ghr and the tables (asynchronous-read distributed RAM).
- Block and slot addressing:
  - Block base = pc with low log2(FETCH_WIDTH)+2 bits cleared.
  - Slot i PC = base + 4i. Slots below pc's slot offset are masked off.
- BTB lookup per slot:
  - Index = slot_pc[BTB_LEN+1:2]; tag = slot_pc[BTB_LEN+TAG_LEN+1:BTB_LEN+2].
  - Hit = valid && tag equal.
  - Entry fields: {valid, tag, target, is_cond}.
- PHT index per slot = slot_pc[PHT_LEN+1:2] XOR zero-extended ghr.
- Taken decision: slot i taken iff slot unmasked && hit && (!is_cond || scnt[1]).
- First taken slot F:
  - pred_mask_o covers slots from the start slot through F inclusive.
  - pred_next_pc_o = BTB target of slot F.
- No taken slot: mask covers start slot to the end of the block; pred_next_pc_o = base + 4*FETCH_WIDTH, wrapping modulo 2^32.
- Fire = pred_valid_o && pred_ready_i.
  - On fire: pc <= pred_next_pc_o.
  - GHR shifts left by one, inserting 1 if F exists and is conditional.
  - GHR inserts 0 if no taken slot but some unmasked conditional hit exists.
  - Otherwise GHR is unchanged.
- Stall: pc and ghr hold while valid && !ready. Outputs may change during a stall only because of update writes; the consumer samples on fire.
- Flush priority: flush_i beats fire; pc <= redir_addr_i, ghr <= redir_ghr_i.
- Training (RUN, upd_valid_i):
  - If upd_is_cond_i, PHT[upd_pc_i[PHT_LEN+1:2] XOR upd_ghr_i] <= saturating ±1 of its current value (+1 if taken). Saturates at 3 and 0.
  - If upd_btb_we_i, write the BTB entry {1, tag(upd_pc_i), upd_target_i, upd_is_cond_i}.
- Write/read same index in the same cycle: the read returns the old value; the new value is visible next cycle.

Test Plan:
- rst high 1 cycle, FETCH_WIDTH=2, PHT_DEPTH=1024 -> pred_valid_o=0 for 1024 cycles, 1 at cycle 1025; pred_pc_o=32'h1c000000, pred_mask_o=2'b11, pred_next_pc_o=32'h1c000008.
- Start PC 32'h1c000004 -> pred_mask_o=2'b10, pred_next_pc_o=32'h1c000008.
- BTB write pc=32'h1c000010, target=32'h1c000100, is_cond=0; then fetch 32'h1c000010 -> pred_taken_o=2'b01, pred_mask_o=2'b01, pred_next_pc_o=32'h1c000100, GHR unchanged.
- Conditional at 32'h1c000020 trained taken twice with GHR 0 -> PHT 01->10->11, scnt=2'b11, taken; a fire then makes ghr=10'b1. Training not-taken 4 times saturates the counter at 00.
- Flush (redir 32'h1c000200, ghr 10'h3AA) same cycle as fire -> pc=32'h1c000200, ghr=10'h3AA; fire ignored.
- pred_ready_i=0 for 5 cycles -> pc and ghr held; rst in mid-run -> CLEAR restarts, pc=INIT_PC, ghr=0.
